// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between two request ports,
// with a registered result slot per port. Optional perf counters: SHIFT_ARB_PERF_EN.
module shift_arbiter #(
  parameter int DATA_W = 32
`ifdef SHIFT_ARB_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [3:0]        req_op0,
  input  logic [3:0]        req_op1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_data0,
  output logic [DATA_W-1:0] resp_data1,
  output logic [1:0]        resp_err
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_grants0,
  output logic [CNT_W-1:0]  perf_grants1,
  output logic [CNT_W-1:0]  perf_conflicts
`endif
);

  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  logic              last_grant_q, last_grant_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_data0_q, resp_data0_d;
  logic [DATA_W-1:0] resp_data1_q, resp_data1_d;

  logic [1:0]        slot_free, elig, grant;
  logic [DATA_W-1:0] sh_a, sh_res;
  logic [4:0]        sh_amt;
  logic [3:0]        sh_op;
  logic              sh_err;

  // Only the low five bits of the shift amount matter.
  logic unused_b;
  assign unused_b = ^{req_b0[DATA_W-1:5], req_b1[DATA_W-1:5]};

  // A slot that is draining this cycle can be refilled in the same cycle.
  always_comb begin
    slot_free = ~resp_valid_q | resp_ready;
    elig      = req_valid & slot_free;
    grant     = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    sh_a   = grant[1] ? req_a1 : req_a0;
    sh_amt = grant[1] ? req_b1[4:0] : req_b0[4:0];
    sh_op  = grant[1] ? req_op1 : req_op0;
    sh_res = '0;
    sh_err = 1'b0;
    case (sh_op)
      OP_SLL:  sh_res = sh_a << sh_amt;
      OP_SRL:  sh_res = sh_a >> sh_amt;
      OP_SRA:  sh_res = $signed(sh_a) >>> sh_amt;
      default: sh_err = 1'b1;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_data0_d = resp_data0_q;
    resp_data1_d = resp_data1_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        resp_valid_d[i] = 1'b1;
        resp_err_d[i]   = sh_err;
      end else if (resp_ready[i]) begin
        resp_valid_d[i] = 1'b0;
      end
    end
    if (grant[0]) resp_data0_d = sh_res;
    if (grant[1]) resp_data1_d = sh_res;
    last_grant_d = (|grant) ? grant[1] : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_err_q   <= 2'b00;
      resp_data0_q <= '0;
      resp_data1_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data0_q <= resp_data0_d;
      resp_data1_q <= resp_data1_d;
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data0 = resp_data0_q;
  assign resp_data1 = resp_data1_q;

`ifdef SHIFT_ARB_PERF_EN
  logic [CNT_W-1:0] perf_g0_q, perf_g0_d;
  logic [CNT_W-1:0] perf_g1_q, perf_g1_d;
  logic [CNT_W-1:0] perf_cf_q, perf_cf_d;

  // Saturating counters: hold at all ones instead of wrapping.
  always_comb begin
    perf_g0_d = perf_g0_q;
    perf_g1_d = perf_g1_q;
    perf_cf_d = perf_cf_q;
    if (grant[0] && !(&perf_g0_q)) perf_g0_d = perf_g0_q + CNT_W'(1);
    if (grant[1] && !(&perf_g1_q)) perf_g1_d = perf_g1_q + CNT_W'(1);
    if ((&elig) && !(&perf_cf_q))  perf_cf_d = perf_cf_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_g0_q <= '0;
      perf_g1_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_g0_q <= perf_g0_d;
      perf_g1_q <= perf_g1_d;
      perf_cf_q <= perf_cf_d;
    end
  end

  assign perf_grants0   = perf_g0_q;
  assign perf_grants1   = perf_g1_q;
  assign perf_conflicts = perf_cf_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbiter and result slots.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] ra[2];
  logic [31:0] rb[2];
  logic [3:0]  rop[2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] resp_data0, resp_data1;
  logic [1:0]  resp_err;
`ifdef SHIFT_ARB_PERF_EN
  logic [15:0] perf_grants0, perf_grants1, perf_conflicts;
`endif

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(ra[0]), .req_a1(ra[1]),
    .req_b0(rb[0]), .req_b1(rb[1]),
    .req_op0(rop[0]), .req_op1(rop[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data0(resp_data0), .resp_data1(resp_data1),
    .resp_err(resp_err)
`ifdef SHIFT_ARB_PERF_EN
    , .perf_grants0(perf_grants0), .perf_grants1(perf_grants1),
    .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: which port won last, and the contents of each result slot.
  int          m_last;
  bit          m_vld[2];
  logic [31:0] m_dat[2];
  bit          m_err[2];
  int          m_g0, m_g1, m_cf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, output bit err);
    int amt;
    logic [31:0] r;
    amt = int'(b % 32);
    err = 1'b0;
    r   = 32'h0;
    if (op == 4'd2) r = a << amt;
    else if (op == 4'd6) r = a >> amt;
    else if (op == 4'd7) begin
      r = a >> amt;
      if (a[31]) r = r | ~(32'hFFFF_FFFF >> amt);
    end else err = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] ref_grant();
    int elig[$];
    for (int i = 0; i < 2; i++)
      if (req_valid[i] && (!m_vld[i] || resp_ready[i])) elig.push_back(i);
    if (elig.size() == 0) return 2'b00;
    if (elig.size() == 1) return (elig[0] == 0) ? 2'b01 : 2'b10;
    return (m_last == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_outputs();
    chk("resp_valid", {30'b0, resp_valid}, {30'b0, m_vld[1], m_vld[0]});
    if (m_vld[0]) begin
      chk("resp_data0", resp_data0, m_dat[0]);
      chk("resp_err0", {31'b0, resp_err[0]}, {31'b0, m_err[0]});
    end
    if (m_vld[1]) begin
      chk("resp_data1", resp_data1, m_dat[1]);
      chk("resp_err1", {31'b0, resp_err[1]}, {31'b0, m_err[1]});
    end
`ifdef SHIFT_ARB_PERF_EN
    chk("perf_grants0", {16'b0, perf_grants0}, m_g0);
    chk("perf_grants1", {16'b0, perf_grants1}, m_g1);
    chk("perf_conflicts", {16'b0, perf_conflicts}, m_cf);
`endif
  endtask

  // One clock: check the combinational grant, advance the model, check registered outputs.
  task automatic step(output logic [1:0] g);
    bit e;
    bit both;
    #1;
    g = ref_grant();
    both = req_valid[0] && req_valid[1] && (!m_vld[0] || resp_ready[0]) &&
           (!m_vld[1] || resp_ready[1]);
    chk("req_ready", {30'b0, req_ready}, {30'b0, g});
    for (int i = 0; i < 2; i++) begin
      if (g[i]) begin
        m_vld[i] = 1'b1;
        m_dat[i] = ref_shift(ra[i], rb[i], rop[i], e);
        m_err[i] = e;
      end else if (resp_ready[i]) m_vld[i] = 1'b0;
    end
    if (g != 2'b00) m_last = g[1] ? 1 : 0;
    if (g[0]) m_g0 = sat_inc(m_g0);
    if (g[1]) m_g1 = sat_inc(m_g1);
    if (both) m_cf = sat_inc(m_cf);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_last = 1;
    m_g0 = 0; m_g1 = 0; m_cf = 0;
    for (int i = 0; i < 2; i++) begin
      m_vld[i] = 1'b0; m_dat[i] = 32'h0; m_err[i] = 1'b0;
    end
    chk("rst_resp_valid", {30'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {30'b0, resp_err}, 32'h0);
    chk("rst_data0", resp_data0, 32'h0);
    chk("rst_data1", resp_data1, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic new_req(input int i);
    int r;
    ra[i] = $urandom;
    rb[i] = $urandom;
    r = $urandom_range(0, 7);
    if (r < 2) rop[i] = 4'd2;
    else if (r < 4) rop[i] = 4'd6;
    else if (r < 6) rop[i] = 4'd7;
    else rop[i] = 4'($urandom);
    if ($urandom_range(0, 7) == 0) rb[i] = rb[i] & 32'hFFFF_FFE0;
  endtask

  logic [1:0] g;

  initial begin
    for (int i = 0; i < 2; i++) begin
      ra[i] = 32'h0; rb[i] = 32'h0; rop[i] = 4'd2;
    end
    #1;
    do_reset();
    #1;
    chk("idle_req_ready", {30'b0, req_ready}, 32'h0);

    // Port 0 SLL
    ra[0] = 32'h0000_00F0; rb[0] = 32'd4; rop[0] = 4'd2; req_valid = 2'b01;
    step(g);
    chk("sll_grant", {30'b0, g}, 32'h1);
    chk("sll_valid0", {31'b0, resp_valid[0]}, 32'h1);
    chk("sll_data0", resp_data0, 32'h0000_0F00);
    chk("sll_err0", {31'b0, resp_err[0]}, 32'h0);

    // Port 1 SRA sign fill, then SRL with drain-and-refill
    req_valid = 2'b10;
    ra[1] = 32'h8000_0000; rb[1] = 32'h0000_0021; rop[1] = 4'd7;
    step(g);
    chk("sra_data1", resp_data1, 32'hC000_0000);
    rop[1] = 4'd6; resp_ready = 2'b10;
    step(g);
    chk("srl_data1", resp_data1, 32'h4000_0000);

    // Round-robin after a fresh reset
    req_valid = 2'b00;
    do_reset();
    resp_ready = 2'b11; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step(g);
      chk("rr_grant", {30'b0, g}, (k % 2 == 0) ? 32'h1 : 32'h2);
      if (g[0]) new_req(0);
      if (g[1]) new_req(1);
    end
`ifdef SHIFT_ARB_PERF_EN
    chk("rr_perf_conf", {16'b0, perf_conflicts}, 32'd4);
    chk("rr_perf_g0", {16'b0, perf_grants0}, 32'd2);
    chk("rr_perf_g1", {16'b0, perf_grants1}, 32'd2);
`endif

    // Back-pressure on port 0 while port 1 keeps flowing
    resp_ready = 2'b10; req_valid = 2'b11;
    ra[0] = 32'h1234_5678; rb[0] = 32'd8; rop[0] = 4'd2;
    step(g);
    chk("bp_first_grant", {30'b0, g}, 32'h1);
    ra[0] = 32'h0000_0001; rb[0] = 32'd31; rop[0] = 4'd2;
    for (int k = 0; k < 3; k++) begin
      ra[1] = 32'(k + 5); rb[1] = 32'h0; rop[1] = 4'd6;
      step(g);
      chk("bp_grant_p1", {30'b0, g}, 32'h2);
      chk("bp_hold_data0", resp_data0, 32'h3456_7800);
      chk("bp_data1", resp_data1, 32'(k + 5));
    end
    resp_ready = 2'b11;
    step(g);
    chk("bp_refill_grant", {30'b0, g}, 32'h1);
    chk("bp_refill_valid0", {31'b0, resp_valid[0]}, 32'h1);
    chk("bp_refill_data0", resp_data0, 32'h8000_0000);

    // Illegal op
    req_valid = 2'b01;
    ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd3; rop[0] = 4'd3;
    step(g);
    chk("ill_data0", resp_data0, 32'h0);
    chk("ill_err0", {31'b0, resp_err[0]}, 32'h1);

    // Fill both slots, then assert reset between clock edges
    resp_ready = 2'b00; req_valid = 2'b11;
    new_req(0); new_req(1);
    step(g);
    if (g[0]) req_valid[0] = 1'b0;
    if (g[1]) req_valid[1] = 1'b0;
    step(g);
    chk("pre_rst_valid", {30'b0, resp_valid}, 32'h3);
    req_valid = 2'b00;
    do_reset();
    resp_ready = 2'b11; req_valid = 2'b11;
    step(g);
    chk("post_rst_grant", {30'b0, g}, 32'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && g[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 3) != 0) begin
            new_req(i); req_valid[i] = 1'b1;
          end
        end else if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          new_req(i); req_valid[i] = 1'b1;
        end
      end
      resp_ready = 2'($urandom);
      step(g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
